sdram_port_arbiter: RTL and testbench

//  Two-master Avalon-MM arbiter sharing the single SDRAM controller slave port.
//  M0 is the Nios II data bridge; M1 is a fabric master (frame/sprite fetch).

---
 rtl/sdram_port_arbiter.sv | 107 ++++++++++
 tb/tb_sdram_port_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: two-master Avalon-MM arbiter onto one SDRAM slave with in-order read-response routing; ARB_FIXED_PRIO_EN selects fixed M0 priority
module sdram_port_arbiter #(
  parameter int ADDR_W   = 27,
  parameter int DATA_W   = 32,
  parameter int MAX_PEND = 4
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   s_address,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  output logic                s_read,
  output logic                s_write,
  input  logic                s_waitrequest,
  input  logic [DATA_W-1:0]   s_readdata,
  input  logic                s_readdatavalid,
  output logic [1:0]          grant,
  output logic                rsp_err
);
  localparam int PW = $clog2(MAX_PEND);
  localparam logic [PW:0] FULL = (PW+1)'(MAX_PEND);
  typedef enum logic [1:0] {IDLE, G0, G1} state_t;
  state_t state, nxt;
  logic last_grant, sel, act, req0, req1, req_g, rd, wr, full, hold, accept, push, pop, tie_g0;
  logic ids [MAX_PEND];
  logic [PW-1:0] wptr, rptr;
  logic [PW:0] count;
  // command mux of the granted master, stall/hold and response routing
  always_comb begin
    sel = state == G1;
    act = state != IDLE;
    req0 = m0_read | m0_write;
    req1 = m1_read | m1_write;
    req_g = sel ? req1 : req0;
    wr = act && (sel ? m1_write : m0_write);
    rd = act && (sel ? m1_read : m0_read) && !wr;
    full = count == FULL;
    hold = rd && full;
    s_read = rd && !full;
    s_write = wr;
    s_address = act ? (sel ? m1_address : m0_address) : '0;
    s_writedata = act ? (sel ? m1_writedata : m0_writedata) : '0;
    s_byteenable = act ? (sel ? m1_byteenable : m0_byteenable) : '0;
    accept = (rd || wr) && !s_waitrequest && !hold;
    m0_waitrequest = !(state == G0 && !s_waitrequest && !hold);
    m1_waitrequest = !(state == G1 && !s_waitrequest && !hold);
    push = accept && rd;
    pop = s_readdatavalid && count != '0;
    m0_readdatavalid = pop && !ids[rptr];
    m1_readdatavalid = pop && ids[rptr];
    m0_readdata = s_readdata;
    m1_readdata = s_readdata;
    grant = {sel && req1, state == G0 && req0};
`ifdef ARB_FIXED_PRIO_EN
    tie_g0 = 1'b1;
    nxt = (sel && !req0) ? G1 : G0;
`else
    tie_g0 = last_grant;
    nxt = sel ? (req0 ? G0 : G1) : (req1 ? G1 : G0);
`endif
  end
  // arbitration FSM; next grant is decided in the accept cycle so transfers run back to back
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state <= IDLE;
      last_grant <= 1'b1;
    end else if (state == IDLE)
      state <= (req0 && req1) ? (tie_g0 ? G0 : G1) : req0 ? G0 : req1 ? G1 : IDLE;
    else if (!req_g)
      state <= IDLE;
    else if (accept) begin
      state <= nxt;
      last_grant <= sel;
    end
  // ID FIFO pointers, occupancy and sticky orphan-response flag
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      rsp_err <= 1'b0;
    end else begin
      wptr <= wptr + PW'(push);
      rptr <= rptr + PW'(pop);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      rsp_err <= rsp_err | (s_readdatavalid && count == '0);
    end
  // ID storage holds the issuing master of each outstanding read
  always_ff @(posedge Clk)
    if (push) ids[wptr] <= sel;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: directed checks of arbitration, ID routing, FIFO hold and rsp_err
module tb_sdram_port_arbiter;
  logic        Clk = 1'b0, Reset = 1'b1;
  logic [26:0] m0_address = '0, m1_address = '0, s_address;
  logic        m0_read = 0, m0_write = 0, m1_read = 0, m1_write = 0;
  logic [31:0] m0_writedata = '0, m1_writedata = '0, s_writedata, s_readdata = '0;
  logic [3:0]  m0_byteenable = '0, m1_byteenable = '0, s_byteenable;
  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata;
  logic        s_read, s_write, s_waitrequest = 0, s_readdatavalid = 0, rsp_err;
  logic [1:0]  grant;
  int checks = 0, errors = 0;
  logic [1:0]  exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [26:0] exp_a [4] = '{27'h200, 27'h300, 27'h200, 27'h300};
  logic [31:0] rsp_d [4] = '{32'hA, 32'hB, 32'hC, 32'hD};
  logic        seen;

  sdram_port_arbiter dut (
    .Clk(Clk), .Reset(Reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .s_address(s_address), .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_read(s_read), .s_write(s_write), .s_waitrequest(s_waitrequest),
    .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .grant(grant), .rsp_err(rsp_err)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset;
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0; s_readdatavalid = 0;
    Reset = 1;
    tick; tick;
    Reset = 0;
  endtask

  initial begin
    do_reset;
    #1;
    chk("rst_m0_wait", m0_waitrequest, 1);
    chk("rst_m1_wait", m1_waitrequest, 1);
    chk("rst_grant", grant, 0);
    chk("rst_sread", s_read, 0);
    // single M0 write
    m0_write = 1; m0_address = 27'h100; m0_writedata = 32'hDEADBEEF; m0_byteenable = 4'hF;
    #1;
    chk("wr_t_swrite", s_write, 0);
    chk("wr_t_wait", m0_waitrequest, 1);
    tick; #1;
    chk("wr_t1_swrite", s_write, 1);
    chk("wr_t1_addr", s_address, 27'h100);
    chk("wr_t1_data", s_writedata, 32'hDEADBEEF);
    chk("wr_t1_wait", m0_waitrequest, 0);
    chk("wr_t1_grant", grant, 2'b01);
    tick;
    m0_write = 0;
    #1;
    chk("wr_t2_grant", grant, 0);
    chk("wr_t2_swrite", s_write, 0);
    tick;
    // alternating continuous reads and routed responses
    do_reset;
    m0_read = 1; m0_address = 27'h200; m1_read = 1; m1_address = 27'h300;
    #1;
    chk("rr_idle_grant", grant, 0);
    tick;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr_grant%0d", i), grant, exp_g[i]);
      chk($sformatf("rr_sread%0d", i), s_read, 1);
      chk($sformatf("rr_addr%0d", i), s_address, exp_a[i]);
      tick;
    end
    #1;
    chk("rr_full_sread", s_read, 0);
    chk("rr_full_wait", m0_waitrequest, 1);
    m0_read = 0; m1_read = 0;
    tick;
    for (int i = 0; i < 4; i++) begin
      s_readdatavalid = 1; s_readdata = rsp_d[i];
      #1;
      chk($sformatf("rsp_m0v%0d", i), m0_readdatavalid, (i % 2) == 0);
      chk($sformatf("rsp_m1v%0d", i), m1_readdatavalid, (i % 2) == 1);
      chk($sformatf("rsp_data%0d", i), (i % 2) ? m1_readdata : m0_readdata, rsp_d[i]);
      tick;
    end
    s_readdatavalid = 0;
    #1;
    chk("rsp_none_err", rsp_err, 0);
    // FIFO full hold with M1
    do_reset;
    m1_read = 1; m1_address = 27'h40;
    tick;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("hold_sread%0d", i), s_read, 1);
      chk($sformatf("hold_wait%0d", i), m1_waitrequest, 0);
      tick;
    end
    #1;
    chk("hold5_sread", s_read, 0);
    chk("hold5_wait", m1_waitrequest, 1);
    tick;
    s_readdatavalid = 1; s_readdata = 32'h55;
    #1;
    chk("hold_pop_sread", s_read, 0);
    chk("hold_pop_m1v", m1_readdatavalid, 1);
    tick;
    s_readdatavalid = 0;
    #1;
    chk("hold_rel_sread", s_read, 1);
    chk("hold_rel_wait", m1_waitrequest, 0);
    tick;
    m1_read = 0;
    // orphan response
    do_reset;
    s_readdatavalid = 1; s_readdata = 32'h77;
    #1;
    chk("orph_m0v", m0_readdatavalid, 0);
    chk("orph_m1v", m1_readdatavalid, 0);
    chk("orph_err_pre", rsp_err, 0);
    tick;
    s_readdatavalid = 0;
    #1;
    chk("orph_err", rsp_err, 1);
    tick; #1;
    chk("orph_err_sticky", rsp_err, 1);
    // reset in the middle of a read
    m0_read = 1; m0_address = 27'h80;
    tick; #1;
    chk("mid_sread_pre", s_read, 1);
    Reset = 1;
    #1;
    chk("mid_m0_wait", m0_waitrequest, 1);
    chk("mid_m1_wait", m1_waitrequest, 1);
    chk("mid_sread", s_read, 0);
    chk("mid_swrite", s_write, 0);
    chk("mid_grant", grant, 0);
    chk("mid_err", rsp_err, 0);
    m0_read = 0;
    tick;
    Reset = 0;
    s_readdatavalid = 1;
    tick;
    s_readdatavalid = 0;
    #1;
    chk("mid_late_err", rsp_err, 1);
    // both masters writing continuously
    do_reset;
    m0_write = 1; m0_address = 27'h10; m1_write = 1; m1_address = 27'h20;
    tick;
`ifdef ARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("fix_grant%0d", i), grant, 2'b01);
      chk($sformatf("fix_m1wait%0d", i), m1_waitrequest, 1);
      tick;
    end
    m0_write = 0;
    seen = 0;
    for (int i = 0; i < 3 && !seen; i++) begin
      tick; #1;
      seen = grant == 2'b10;
    end
    chk("fix_m1_granted", seen, 1);
`else
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("fair_grant%0d", i), grant, exp_g[i]);
      chk($sformatf("fair_swrite%0d", i), s_write, 1);
      tick;
    end
    seen = 1;
`endif
    m0_write = 0; m1_write = 0;
    tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
